// File: rtl/point_cloud_loader.sv
// point_cloud_loader: packs an (x,y,z) point stream into the x/y/z BRAMs over port B,
// writes the count header and start flag, then waits for and clears the filter's done flag.
module point_cloud_loader #(
    parameter int N          = 16,
    parameter int MAX_POINTS = 4096
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [N-1:0]     s_x,
    input  logic [N-1:0]     s_y,
    input  logic [N-1:0]     s_z,
    input  logic             s_last,
    output logic [31:0]      addr_x,
    output logic [31:0]      addr_y,
    output logic [31:0]      addr_z,
    output logic [8*N-1:0]   write_in_x,
    output logic [8*N-1:0]   write_in_y,
    output logic [8*N-1:0]   write_in_z,
    input  logic [8*N-1:0]   read_out_z,
    output logic             en_x,
    output logic             en_y,
    output logic             en_z,
    output logic [15:0]      we_x,
    output logic [15:0]      we_y,
    output logic [15:0]      we_z,
    output logic             busy,
    output logic             done,
    output logic [31:0]      point_count,
    output logic             overflow
);
    localparam int W = 8 * N;

    typedef enum logic [2:0] {IDLE, ACCEPT, FLUSH, HDR_X, HDR_Y, WAIT_DONE, CLR_Z, DONE} state_t;

    state_t         state, state_n;
    logic [2:0]     lane;
    logic [31:0]    word;
    logic [W-1:0]   buf_x, buf_y, buf_z;
    logic [W-1:0]   pack_x, pack_y, pack_z;
    logic           primed;
    logic           hs, store, partial, wr;
    logic [31:0]    count, word_addr;
    logic           unused_z;

    assign unused_z = ^read_out_z[W-1:32];
    assign busy     = state != IDLE;
    assign done     = state == DONE;

    always_comb begin
        s_ready   = !reset && (state == IDLE || state == ACCEPT);
        hs        = s_valid && s_ready;
        count     = state == IDLE ? 32'd0 : point_count;
        store     = hs && count < 32'(MAX_POINTS);
        // buffer still holds points after this handshake -> a flush word is needed
        partial   = store ? lane != 3'd7 : lane != 3'd0;
        wr        = (store && lane == 3'd7) || state == FLUSH;
        word_addr = (word + 32'd1) << 4;
        pack_x    = buf_x;
        pack_y    = buf_y;
        pack_z    = buf_z;
        pack_x[lane*N +: N] = s_x;
        pack_y[lane*N +: N] = s_y;
        pack_z[lane*N +: N] = s_z;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, ACCEPT: if (hs) state_n = s_last ? (partial ? FLUSH : HDR_X) : ACCEPT;
            FLUSH:        state_n = HDR_X;
            HDR_X:        state_n = HDR_Y;
            HDR_Y:        state_n = WAIT_DONE;
            WAIT_DONE:    if (primed && read_out_z[31:0] == 32'h0000_0FFF) state_n = CLR_Z;
            CLR_Z:        state_n = DONE;
            default:      state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            {addr_x, addr_y, addr_z}             <= '0;
            {write_in_x, write_in_y, write_in_z} <= '0;
            {en_x, en_y, en_z}                   <= '0;
            {we_x, we_y, we_z}                   <= '0;
            {buf_x, buf_y, buf_z}                <= '0;
            lane        <= '0;
            word        <= '0;
            primed      <= 1'b0;
            point_count <= '0;
            overflow    <= 1'b0;
        end else begin
            {addr_x, addr_y, addr_z}             <= '0;
            {write_in_x, write_in_y, write_in_z} <= '0;
            {en_x, en_y, en_z}                   <= '0;
            {we_x, we_y, we_z}                   <= '0;
            if (hs && state == IDLE) overflow <= 1'b0;
            if (store) point_count <= count + 32'd1;
            else if (hs) overflow <= 1'b1;
            if (wr) begin
                {addr_x, addr_y, addr_z} <= {3{word_addr}};
                write_in_x <= state == FLUSH ? buf_x : pack_x;
                write_in_y <= state == FLUSH ? buf_y : pack_y;
                write_in_z <= state == FLUSH ? buf_z : pack_z;
                {en_x, en_y, en_z} <= 3'b111;
                {we_x, we_y, we_z} <= {3{16'hFFFF}};
                {buf_x, buf_y, buf_z} <= '0;
                lane <= '0;
                word <= word + 32'd1;
            end else if (store) begin
                buf_x <= pack_x;
                buf_y <= pack_y;
                buf_z <= pack_z;
                lane  <= lane + 3'd1;
            end
            case (state)
                HDR_X: begin
                    en_x       <= 1'b1;
                    we_x       <= 16'h000F;
                    write_in_x <= W'(point_count);
                end
                HDR_Y: begin
                    en_y       <= 1'b1;
                    we_y       <= 16'h000F;
                    write_in_y <= W'(1);
                    en_z       <= 1'b1;
                    primed     <= 1'b0;
                end
                WAIT_DONE: begin
                    // read request is on the bus from the first WAIT_DONE cycle,
                    // so read data is trusted from the second cycle on
                    en_z   <= 1'b1;
                    primed <= 1'b1;
                    if (state_n == CLR_Z) we_z <= 16'h000F;
                end
                DONE:    word <= '0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_point_cloud_loader.sv
// tb_point_cloud_loader: scoreboard bench; expected BRAM writes are queued when a cloud is driven
// and popped by a bus monitor as the loader issues them.
module tb_point_cloud_loader;
    logic         clock = 0, reset = 1, s_valid = 0, s_last = 0, sel = 0;
    logic [15:0]  s_x = 0, s_y = 0, s_z = 0;
    logic [127:0] read_out_z = 0;
    logic         rdy [2], bsy [2], dn [2], ov [2];
    logic [31:0]  pc [2];
    logic [31:0]  badr [2][3];
    logic [127:0] bdat [2][3];
    logic         ben [2][3];
    logic [15:0]  bwe [2][3];
    int checks = 0, errors = 0;

    typedef struct packed {
        logic [2:0]        m;
        logic [31:0]       a;
        logic [2:0][127:0] d;
        logic [15:0]       we;
    } wr_t;
    wr_t q[$];

    always #5 clock = ~clock;

    point_cloud_loader dut (
        .clock(clock), .reset(reset), .s_valid(s_valid && !sel), .s_ready(rdy[0]),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
        .addr_x(badr[0][0]), .addr_y(badr[0][1]), .addr_z(badr[0][2]),
        .write_in_x(bdat[0][0]), .write_in_y(bdat[0][1]), .write_in_z(bdat[0][2]),
        .read_out_z(read_out_z),
        .en_x(ben[0][0]), .en_y(ben[0][1]), .en_z(ben[0][2]),
        .we_x(bwe[0][0]), .we_y(bwe[0][1]), .we_z(bwe[0][2]),
        .busy(bsy[0]), .done(dn[0]), .point_count(pc[0]), .overflow(ov[0])
    );

    point_cloud_loader #(.MAX_POINTS(16)) dut_s (
        .clock(clock), .reset(reset), .s_valid(s_valid && sel), .s_ready(rdy[1]),
        .s_x(s_x), .s_y(s_y), .s_z(s_z), .s_last(s_last),
        .addr_x(badr[1][0]), .addr_y(badr[1][1]), .addr_z(badr[1][2]),
        .write_in_x(bdat[1][0]), .write_in_y(bdat[1][1]), .write_in_z(bdat[1][2]),
        .read_out_z(read_out_z),
        .en_x(ben[1][0]), .en_y(ben[1][1]), .en_z(ben[1][2]),
        .we_x(bwe[1][0]), .we_y(bwe[1][1]), .we_z(bwe[1][2]),
        .busy(bsy[1]), .done(dn[1]), .point_count(pc[1]), .overflow(ov[1])
    );

    always @(negedge clock) begin
        logic [2:0] m;
        logic       bad;
        wr_t        e;
        for (int p = 0; p < 3; p++) m[p] = ben[sel][p] && bwe[sel][p] != 16'h0;
        if (m != 3'b000 && !reset) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: mask=%b addr_x=%h addr_y=%h addr_z=%h, required no write", m, badr[sel][0], badr[sel][1], badr[sel][2]);
            end else begin
                e = q.pop_front();
                bad = m != e.m;
                for (int p = 0; p < 3; p++)
                    if (m[p] && (badr[sel][p] != e.a || bdat[sel][p] != e.d[p] || bwe[sel][p] != e.we)) bad = 1;
                if (bad) begin
                    errors++;
                    $display("FAIL write_content: got mask=%b addr=%h/%h/%h we=%h/%h/%h x=%h y=%h z=%h, required mask=%b addr=%h we=%h x=%h y=%h z=%h",
                             m, badr[sel][0], badr[sel][1], badr[sel][2], bwe[sel][0], bwe[sel][1], bwe[sel][2],
                             bdat[sel][0], bdat[sel][1], bdat[sel][2], e.m, e.a, e.we, e.d[0], e.d[1], e.d[2]);
                end
            end
        end
    end

    task automatic drive(input logic [15:0] x, y, z, input logic last, inout int stalls);
        int t = 0;
        s_valid = 1; s_x = x; s_y = y; s_z = z; s_last = last;
        while (!rdy[sel] && t < 50) begin @(posedge clock); #1; t++; end
        stalls += t;
        if (t >= 50) begin
            checks++; errors++;
            $display("FAIL handshake_timeout: s_ready=%b after %0d cycles, required 1", rdy[sel], t);
        end
        @(posedge clock); #1;
        s_valid = 0; s_last = 0;
    endtask

    task automatic run_cloud(input int n, input int maxp, input bit rnd, input bit gaps, input int hold, input bit no_stall);
        logic [15:0] px [32], py [32], pz [32];
        wr_t e;
        int  st, t, stalls = 0;
        bit  early = 0, rd_bad = 0, rq_bad = 0;
        for (int i = 0; i < n; i++) begin
            px[i] = rnd ? 16'($urandom_range(1, 65535)) : 16'(i + 1);
            py[i] = rnd ? 16'($urandom_range(1, 65535)) : 16'(16 + i);
            pz[i] = rnd ? 16'($urandom_range(1, 65535)) : 16'(32 + i);
        end
        st = n < maxp ? n : maxp;
        for (int k = 0; k * 8 < st; k++) begin
            e = '0; e.m = 3'b111; e.a = 32'(16 * (k + 1)); e.we = 16'hFFFF;
            for (int l = 0; l < 8 && k * 8 + l < st; l++) begin
                e.d[0][16*l +: 16] = px[k*8+l];
                e.d[1][16*l +: 16] = py[k*8+l];
                e.d[2][16*l +: 16] = pz[k*8+l];
            end
            q.push_back(e);
        end
        e = '0; e.m = 3'b001; e.we = 16'h000F; e.d[0] = 128'(st); q.push_back(e);
        e = '0; e.m = 3'b010; e.we = 16'h000F; e.d[1] = 128'd1;   q.push_back(e);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                t = $urandom_range(0, 2);
                repeat (t) begin @(posedge clock); #1; end
            end
            drive(px[i], py[i], pz[i], i == n - 1, stalls);
        end
        if (no_stall) begin
            checks++;
            if (stalls != 0) begin errors++; $display("FAIL s_ready_stall: stalled %0d cycles, required 0", stalls); end
        end
        t = 0;
        while (!(ben[sel][2] && bwe[sel][2] == 16'h0) && t < 100) begin
            if (rdy[sel]) rd_bad = 1;
            @(posedge clock); #1; t++;
        end
        checks++;
        if (t >= 100) begin errors++; $display("FAIL wait_done_entry: no z read after %0d cycles, required within 100", t); end
        for (int i = 0; i < hold; i++) begin
            if (!(ben[sel][2] && bwe[sel][2] == 16'h0 && badr[sel][2] == 32'h0)) rq_bad = 1;
            if (rdy[sel]) rd_bad = 1;
            if (dn[sel]) early = 1;
            @(posedge clock); #1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL done_early: done=1 before flag, required 0"); end
        checks++;
        if (rq_bad) begin errors++; $display("FAIL z_poll: en_z/we_z/addr_z not 1/0/0 during wait, required 1/0/0"); end
        e = '0; e.m = 3'b100; e.we = 16'h000F; q.push_back(e);
        read_out_z = 128'h0FFF;
        t = 0;
        while (!dn[sel] && t < 10) begin
            if (rdy[sel]) rd_bad = 1;
            @(posedge clock); #1; t++;
        end
        checks++;
        if (!dn[sel]) begin errors++; $display("FAIL done_pulse: done=%b after %0d cycles, required 1", dn[sel], t); end
        @(posedge clock); #1;
        read_out_z = 0;
        checks++;
        if (dn[sel] !== 1'b0 || bsy[sel] !== 1'b0) begin
            errors++; $display("FAIL done_end: done=%b busy=%b, required 0 0", dn[sel], bsy[sel]);
        end
        checks++;
        if (rd_bad) begin errors++; $display("FAIL s_ready_after_last: s_ready=1 after last point, required 0"); end
        checks++;
        if (pc[sel] !== 32'(st)) begin errors++; $display("FAIL point_count: got %0d, required %0d", pc[sel], st); end
        checks++;
        if (ov[sel] !== (n > maxp)) begin errors++; $display("FAIL overflow: got %b, required %b", ov[sel], n > maxp); end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL writes_missing: %0d pending, required 0", q.size()); end
    endtask

    task automatic check_zero(input int d);
        bit z = rdy[d] || bsy[d] || dn[d] || ov[d] || pc[d] != 0;
        for (int p = 0; p < 3; p++)
            if (ben[d][p] || bwe[d][p] != 0 || badr[d][p] != 0 || bdat[d][p] != 0) z = 1;
        checks++;
        if (z) begin
            errors++;
            $display("FAIL reset_outputs: dut%0d ready=%b busy=%b done=%b ovf=%b count=%0d, required all 0", d, rdy[d], bsy[d], dn[d], ov[d], pc[d]);
        end
    endtask

    task automatic test_reset;
        reset = 1;
        repeat (3) @(posedge clock);
        #1;
        check_zero(0);
        check_zero(1);
        reset = 0;
        #1;
        checks++;
        if (rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: ready=%b busy=%b, required 1 0", rdy[0], bsy[0]);
        end
    endtask

    task automatic test_full_word;
        run_cloud(8, 4096, 0, 0, 10, 1);
    endtask

    task automatic test_flush;
        run_cloud(3, 4096, 1, 0, 2, 1);
    endtask

    task automatic test_gaps;
        run_cloud(17, 4096, 1, 1, 3, 0);
    endtask

    task automatic test_overflow;
        sel = 1;
        run_cloud(20, 16, 1, 0, 2, 1);
        sel = 0;
    endtask

    task automatic test_back_to_back;
        run_cloud(1, 4096, 1, 0, 1, 1);
        run_cloud(16, 4096, 1, 0, 1, 1);
    endtask

    task automatic test_reset_mid;
        int stalls = 0;
        for (int i = 0; i < 5; i++) drive(16'(i + 100), 16'(i + 200), 16'(i + 300), 0, stalls);
        reset = 1;
        @(posedge clock); #1;
        check_zero(0);
        reset = 0;
        repeat (3) begin @(posedge clock); #1; end
        checks++;
        if (bsy[0] !== 1'b0 || q.size() != 0) begin
            errors++; $display("FAIL reset_mid_idle: busy=%b pending=%0d, required 0 0", bsy[0], q.size());
        end
        run_cloud(2, 4096, 1, 0, 2, 1);
    endtask

    initial begin
        test_reset;
        test_full_word;
        test_flush;
        test_gaps;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/point_cloud_loader.md
Name: point_cloud_loader

Overview:
- Writer side of the point-cloud BRAM protocol: accepts a stream of (x,y,z) points, packs them into the x/y/z BRAMs, writes the header and start flag, then waits for the filter's completion flag.
- Drives port B of the three dual-port BRAMs. The filter-side BRAM interface owns port A.
- Port B is driven only outside the filter's run window: from first accepted point until `y` flag write, and during WAIT_DONE, which is reads plus a single clear.

Parameters:
- N, 16, bits per coordinate; fixed 8 lanes per 128-bit word (N*8=128).
- MAX_POINTS, 4096, capacity in points; must be a multiple of 8.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- s_valid  in  1  point valid
- s_ready  out  1  loader can accept
- s_x, s_y, s_z  in  N each  point coordinates
- s_last  in  1  final point of cloud, qualified by s_valid
- addr_x, addr_y, addr_z  out  32 each  BRAM byte addresses
- write_in_x, write_in_y, write_in_z  out  128 each  BRAM write data
- read_out_z  in  128  BRAM z read data, 1-cycle latency
- en_x, en_y, en_z  out  1 each  BRAM enables
- we_x, we_y, we_z  out  16 each  byte write enables
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on cloud completion
- point_count  out  32  points stored for current/last cloud
- overflow  out  1  sticky until next cloud; set when points were dropped

Behaviour:
- Reset values: all outputs 0; state IDLE; lane/word counters 0.
- Memory map:
  - Header word at address 0: x[31:0] = point count; y[31:0] = start flag (1); z[31:0] = done flag (32'h00000FFF written by filter).
  - Point i goes to word k=i/8 at byte address 16*(k+1), lane i%8, bits [16*(i%8)+15 : 16*(i%8)].
- All BRAM outputs are registered. we=0 on every cycle not listed below.
- IDLE:
  - s_ready=1.
  - First s_valid handshake → ACCEPT; that point is lane 0, point_count=1, overflow cleared.
- ACCEPT:
  - s_ready=1. Each handshake places s_x/s_y/s_z into the lane buffer.
  - On the handshake filling lane 7, the next-edge outputs are:
    - write_in_* = full packed word.
    - addr_* = 16*(k+1).
    - we_* = 16'hFFFF.
    - en_* = 1.
    - The lane buffer clears.
  - No stall: a write and the next accept overlap.
- Overflow:
  - Handshakes with point_count == MAX_POINTS are consumed without storing; overflow=1.
  - s_last still terminates the cloud.
- s_last:
  - On an s_last handshake with a partial lane buffer (lanes 0..j, j<7), → FLUSH.
  - FLUSH writes the word with unused lanes zero, we=16'hFFFF, then → HDR_X.
  - If the last point filled lane 7, or the cloud overflowed with an empty buffer, go directly to HDR_X.
- Header writes:
  - HDR_X: s_ready=0; addr_x=0, write_in_x[31:0]=point_count, we_x=16'h000F; → HDR_Y.
  - HDR_Y: addr_y=0, write_in_y[31:0]=1, we_y=16'h000F; → WAIT_DONE.
  - Ordering is mandatory: the `y` flag is written strictly after the last data word and the count.
- WAIT_DONE:
  - addr_z=0, en_z=1, we_z=0 every cycle.
  - read_out_z is evaluated only from the 2nd cycle in state onward (read latency).
  - When read_out_z[31:0]==32'h00000FFF → CLR_Z.
  - Waits indefinitely otherwise.
- CLR_Z: addr_z=0, write_in_z=0, we_z=16'h000F; → DONE.
- DONE: done=1 for exactly one cycle; → IDLE. point_count and overflow hold until the next cloud starts.
- s_ready=0 in FLUSH, HDR_X, HDR_Y, WAIT_DONE, CLR_Z, DONE.
- Width rules:
  - point_count is 32-bit and saturates at MAX_POINTS.
  - Word address is 16*(k+1), computed in 32 bits.
  - No wrap-around is possible given MAX_POINTS.
- Simultaneous events:
  - An s_last handshake on lane 7 performs the data write and then → HDR_X with no FLUSH.
  - s_valid with s_last in IDLE gives a single-point cloud: → FLUSH.
- Reset mid-operation: returns to IDLE next edge; in-flight partial word and header are discarded; no BRAM writes that cycle.

Test Plan:
- 8 points (x=1..8, y=0x10..0x17, z=0x20..0x27), last on 8th:
  - One write at addr 16 with we=FFFF, x word = 0x0008_0007_..._0001.
  - Then addr 0 x=8 (we=000F), then y=1.
  - s_ready stays high for all 8 handshakes.
- 3 points then s_last:
  - FLUSH writes addr 16 with lanes 3..7 zero.
  - Header count=3.
  - No accept during FLUSH/HDR.
- 17 points with random s_valid gaps:
  - Writes at 16, 32, 48; the word at 48 has only lane 0 nonzero.
  - count=17.
- MAX_POINTS=16, send 20 points:
  - Exactly 2 data writes.
  - count=16, overflow=1, header x=16.
- Done handshake:
  - In WAIT_DONE, hold read_out_z=0 for 10 cycles, then 0xFFF.
  - Required: no done early; then one z clear (addr 0, data 0, we_z=000F) and a single-cycle done; busy drops the next cycle.
- Reset asserted after 5 points accepted:
  - No further writes; all outputs 0.
  - A new 2-point cloud afterwards writes addr 16 and count=2 correctly.
